// File: rtl/step_scheduler.sv
// step_scheduler: per-tick stepper pulse scheduler with accumulator spacing.
// Optional soft position limit when STEP_SCHED_POS_LIMIT_EN is defined.
module step_scheduler #(
  parameter int CLK_PER_TICK = 500_000,
  parameter int PULSE_WIDTH  = 100,
  parameter int DIR_SETUP    = 50,
  parameter int MAX_STEPS    = 200,
  parameter int POS_LIMIT    = 1600
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sim_tick,
  input  logic signed [15:0] delta_steps,
  output logic               step,
  output logic               dir,
  output logic               busy,
  output logic signed [15:0] position,
  output logic               overrun,
  output logic               saturated,
  output logic               limit_hit
);

  localparam int AW = $clog2(CLK_PER_TICK + MAX_STEPS) + 1;
  localparam int NW = $clog2(MAX_STEPS + 1);
  localparam int PW = $clog2(PULSE_WIDTH + 1);
  localparam int SW = $clog2(DIR_SETUP + 1);

  localparam logic [AW-1:0] PERIOD = AW'(CLK_PER_TICK);
  localparam logic [AW-1:0] HALF   = AW'(CLK_PER_TICK / 2);
  localparam logic [16:0]   MAX17  = 17'(MAX_STEPS);
  localparam logic [NW-1:0] MAXN   = NW'(MAX_STEPS);
  localparam logic [PW-1:0] PLAST  = PW'(PULSE_WIDTH - 1);
  localparam logic [SW-1:0] SLOAD  = SW'(DIR_SETUP);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    RUN
  } state_t;

  state_t        state;
  logic [AW-1:0] acc;
  logic [NW-1:0] n;
  logic [NW-1:0] remaining;
  logic [PW-1:0] pcnt;
  logic [SW-1:0] scnt;
  logic          sat_d;

  logic [16:0]   mag;
  logic          sat_now;
  logic [NW-1:0] n_new;
  logic          new_dir;
  logic [AW-1:0] acc_sum;
  logic          fire;
  logic          blocked;

  // 17-bit magnitude so -32768 clamps without overflowing
  always_comb begin
    mag     = delta_steps[15] ? (17'd0 - {1'b1, delta_steps})
                              : {1'b0, delta_steps};
    sat_now = mag > MAX17;
    n_new   = sat_now ? MAXN : mag[NW-1:0];
    new_dir = ~delta_steps[15];
    acc_sum = acc + AW'(n);
    fire    = (acc_sum >= PERIOD) && (remaining != '0);
  end

`ifdef STEP_SCHED_POS_LIMIT_EN
  localparam logic signed [15:0] PLIM = 16'(POS_LIMIT);
  localparam logic signed [15:0] NLIM = -PLIM;

  logic lim_dir;

  always_comb begin
    blocked = dir ? (position >= PLIM) : (position <= NLIM);
  end

  // sticky until motion resumes away from the limit that was hit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      limit_hit <= 1'b0;
      lim_dir   <= 1'b1;
    end else if (!sim_tick && state == RUN && fire) begin
      if (blocked) begin
        limit_hit <= 1'b1;
        lim_dir   <= dir;
      end else if (dir != lim_dir) begin
        limit_hit <= 1'b0;
      end
    end
  end
`else
  assign blocked   = 1'b0;
  assign limit_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      n         <= '0;
      remaining <= '0;
      pcnt      <= '0;
      scnt      <= '0;
      sat_d     <= 1'b0;
      step      <= 1'b0;
      dir       <= 1'b1;
      busy      <= 1'b0;
      position  <= '0;
      overrun   <= 1'b0;
      saturated <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      sat_d     <= 1'b0;
      saturated <= sat_d;

      // pulse timer runs independently so retargeting never truncates it
      if (step) begin
        if (pcnt == '0) step <= 1'b0;
        else pcnt <= pcnt - 1'b1;
      end

      if (sim_tick) begin
        overrun   <= (state != IDLE) && (remaining != '0);
        sat_d     <= sat_now;
        n         <= n_new;
        remaining <= n_new;
        acc       <= HALF;
        if (n_new == '0) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else if (new_dir != dir) begin
          dir   <= new_dir;
          scnt  <= SLOAD;
          state <= SETUP;
          busy  <= 1'b1;
        end else begin
          state <= RUN;
          busy  <= 1'b1;
        end
      end else begin
        unique case (state)
          IDLE: ;
          SETUP: begin
            if (scnt == '0) state <= RUN;
            else scnt <= scnt - 1'b1;
          end
          RUN: begin
            if (fire) begin
              acc       <= acc_sum - PERIOD;
              remaining <= remaining - 1'b1;
              if (!blocked) begin
                step     <= 1'b1;
                pcnt     <= PLAST;
                position <= dir ? position + 16'sd1
                                : position - 16'sd1;
              end
            end else begin
              acc <= acc_sum;
            end
            if (remaining == '0 && (!step || pcnt == '0)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_step_scheduler.sv
// tb_step_scheduler: directed scenarios for step_scheduler.
// Edge numbers are counted from the edge that samples sim_tick.
module tb_step_scheduler;

  logic               clock;
  logic               reset;
  logic               sim_tick;
  logic signed [15:0] delta;
  logic               step;
  logic               dir;
  logic               busy;
  logic signed [15:0] position;
  logic               overrun;
  logic               saturated;
  logic               limit_hit;

  int n_tests;
  int n_fail;

  int   rise_q[$];
  int   wid_q[$];
  int   ov_cnt;
  int   sat_cnt;
  int   busy_low;
  logic prev_step;
  int   cur_w;

  step_scheduler #(
    .CLK_PER_TICK(1000),
    .PULSE_WIDTH (10),
    .DIR_SETUP   (5),
    .MAX_STEPS   (25),
    .POS_LIMIT   (6)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .sim_tick   (sim_tick),
    .delta_steps(delta),
    .step       (step),
    .dir        (dir),
    .busy       (busy),
    .position   (position),
    .overrun    (overrun),
    .saturated  (saturated),
    .limit_hit  (limit_hit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clear_mon();
    rise_q.delete();
    wid_q.delete();
    ov_cnt    = 0;
    sat_cnt   = 0;
    busy_low  = -1;
    prev_step = 1'b0;
    cur_w     = 0;
  endtask

  task automatic sample(input int e);
    if (step && !prev_step) begin
      rise_q.push_back(e);
      cur_w = 0;
    end
    if (step) cur_w++;
    if (!step && prev_step) wid_q.push_back(cur_w);
    if (overrun) ov_cnt++;
    if (saturated) sat_cnt++;
    if (!busy && busy_low < 0) busy_low = e;
    prev_step = step;
  endtask

  task automatic tick(input logic signed [15:0] d, input int e);
    @(negedge clock);
    sim_tick = 1'b1;
    delta    = d;
    @(posedge clock);
    #1;
    sim_tick = 1'b0;
    delta    = '0;
    sample(e);
  endtask

  task automatic run(input int from_e, input int to_e);
    for (int e = from_e; e <= to_e; e++) begin
      @(posedge clock);
      #1;
      sample(e);
    end
  endtask

  task automatic test_reset();
    logic [5:0] flags;
    reset    = 1'b0;
    sim_tick = 1'b0;
    delta    = '0;
    repeat (3) @(posedge clock);
    #1;
    flags = {step, dir, busy, overrun, saturated, limit_hit};
    n_tests++;
    if (flags !== 6'b010000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 010000", flags);
    end
    n_tests++;
    if (position !== 16'sd0) begin
      n_fail++;
      $display("FAIL reset_pos: got %0d want 0", position);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    n_tests++;
    if (busy !== 1'b0 || step !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy %b step %b want 0 0", busy, step);
    end
  endtask

  task automatic test_pos4();
    int exp_r[4] = '{125, 375, 625, 875};
    clear_mon();
    tick(16'sd4, 0);
    run(1, 999);
    n_tests++;
    if (rise_q.size() != 4) begin
      n_fail++;
      $display("FAIL pos4_count: got %0d want 4", rise_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (rise_q[i] != exp_r[i]) begin
          n_fail++;
          $display("FAIL pos4_rise%0d: got %0d want %0d", i, rise_q[i], exp_r[i]);
        end
      end
    end
    n_tests++;
    if (wid_q.size() != 4) begin
      n_fail++;
      $display("FAIL pos4_widths: got %0d pulses ended want 4", wid_q.size());
    end
    foreach (wid_q[i]) begin
      n_tests++;
      if (wid_q[i] != 10) begin
        n_fail++;
        $display("FAIL pos4_width%0d: got %0d want 10", i, wid_q[i]);
      end
    end
    n_tests++;
    if (dir !== 1'b1 || position !== 16'sd4) begin
      n_fail++;
      $display("FAIL pos4_state: dir %b pos %0d want 1 4", dir, position);
    end
    n_tests++;
    if (busy_low != 885) begin
      n_fail++;
      $display("FAIL pos4_busy_low: got %0d want 885", busy_low);
    end
  endtask

  task automatic test_neg3();
    int exp_r[3] = '{173, 506, 840};
    clear_mon();
    tick(-16'sd3, 0);
    n_tests++;
    if (dir !== 1'b0) begin
      n_fail++;
      $display("FAIL neg3_dir: got %b want 0", dir);
    end
    run(1, 999);
    n_tests++;
    if (rise_q.size() != 3) begin
      n_fail++;
      $display("FAIL neg3_count: got %0d want 3", rise_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (rise_q[i] != exp_r[i]) begin
          n_fail++;
          $display("FAIL neg3_rise%0d: got %0d want %0d", i, rise_q[i], exp_r[i]);
        end
      end
    end
    n_tests++;
    if (position !== 16'sd1 || ov_cnt != 0) begin
      n_fail++;
      $display("FAIL neg3_state: pos %0d overruns %0d want 1 0", position, ov_cnt);
    end
  endtask

  task automatic test_saturate();
    int min_gap;
    clear_mon();
    tick(16'sd100, 0);
    run(1, 999);
    n_tests++;
    if (sat_cnt != 1) begin
      n_fail++;
      $display("FAIL sat_pulses: got %0d want 1", sat_cnt);
    end
    n_tests++;
    if (rise_q.size() != 25) begin
      n_fail++;
      $display("FAIL sat_count: got %0d want 25", rise_q.size());
    end
    min_gap = 1000;
    for (int i = 1; i < rise_q.size(); i++)
      if (rise_q[i] - rise_q[i-1] < min_gap) min_gap = rise_q[i] - rise_q[i-1];
    n_tests++;
    if (min_gap < 40) begin
      n_fail++;
      $display("FAIL sat_spacing: got %0d want >=40", min_gap);
    end
    n_tests++;
    if (rise_q.size() == 0 || rise_q[0] != 26) begin
      n_fail++;
      $display("FAIL sat_first: got %0d want 26",
               rise_q.size() == 0 ? -1 : rise_q[0]);
    end
    n_tests++;
    if (position !== 16'sd26 || dir !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_state: pos %0d dir %b want 26 1", position, dir);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    tick(16'sd4, 0);
    run(1, 299);
    tick(16'sd2, 300);
    run(301, 1299);
    n_tests++;
    if (ov_cnt != 1) begin
      n_fail++;
      $display("FAIL b2b_overrun: got %0d want 1", ov_cnt);
    end
    n_tests++;
    if (rise_q.size() != 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d want 3", rise_q.size());
    end else begin
      n_tests++;
      if (rise_q[0] != 125 || rise_q[1] != 550 || rise_q[2] != 1050) begin
        n_fail++;
        $display("FAIL b2b_rises: got %0d %0d %0d want 125 550 1050",
                 rise_q[0], rise_q[1], rise_q[2]);
      end
    end
    n_tests++;
    if (position !== 16'sd29 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_state: pos %0d busy %b want 29 0", position, busy);
    end
  endtask

  task automatic test_reset_mid_pulse();
    clear_mon();
    tick(16'sd1, 0);
    run(1, 502);
    n_tests++;
    if (step !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pulse_active: got %b want 1", step);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (step !== 1'b0 || position !== 16'sd0) begin
      n_fail++;
      $display("FAIL mid_reset: step %b pos %0d want 0 0", step, position);
    end
    n_tests++;
    if (dir !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_flags: dir %b busy %b want 1 0", dir, busy);
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    clear_mon();
    run(1, 1200);
    n_tests++;
    if (rise_q.size() != 0 || position !== 16'sd0 || busy_low != 1) begin
      n_fail++;
      $display("FAIL post_reset_quiet: pulses %0d pos %0d busy_low %0d want 0 0 1",
               rise_q.size(), position, busy_low);
    end
  endtask

`ifdef STEP_SCHED_POS_LIMIT_EN
  task automatic test_limit();
    clear_mon();
    tick(16'sd8, 0);
    run(1, 999);
    n_tests++;
    if (rise_q.size() != 6 || position !== 16'sd6) begin
      n_fail++;
      $display("FAIL limit_clamp: pulses %0d pos %0d want 6 6",
               rise_q.size(), position);
    end
    n_tests++;
    if (limit_hit !== 1'b1) begin
      n_fail++;
      $display("FAIL limit_set: got %b want 1", limit_hit);
    end
    clear_mon();
    tick(-16'sd1, 0);
    run(1, 999);
    n_tests++;
    if (rise_q.size() != 1 || position !== 16'sd5) begin
      n_fail++;
      $display("FAIL limit_back: pulses %0d pos %0d want 1 5",
               rise_q.size(), position);
    end
    n_tests++;
    if (limit_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL limit_clear: got %b want 0", limit_hit);
    end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_pos4();
    test_neg3();
    test_saturate();
    test_back_to_back();
    test_reset_mid_pulse();
`ifdef STEP_SCHED_POS_LIMIT_EN
    test_limit();
`else
    n_tests++;
    if (limit_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL limit_tied: got %b want 0", limit_hit);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
